// File: rtl/cga_mic_pkg.sv
// Shared types and constants for the microprogram return-address stack controller
// and the stack-bit slices it drives.
package cga_mic_pkg;

  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_PUSH    = 2'd1,
    MODE_POP     = 2'd2,
    MODE_REPLACE = 2'd3
  } mode_e;

  // Slice strobes in slice pin order; S3N is derived from s3 at the encoder.
  typedef struct packed {
    logic load;
    logic s3;
    logic s4ns3n;
    logic s4s3n;
  } strobe_t;

  localparam strobe_t STB_HOLD    = 4'b1010;
  localparam strobe_t STB_PUSH    = 4'b0010;
  localparam strobe_t STB_POP     = 4'b1100;
  localparam strobe_t STB_REPLACE = 4'b1001;

  function automatic strobe_t mode_strobes(input mode_e m);
    case (m)
      MODE_PUSH:    return STB_PUSH;
      MODE_POP:     return STB_POP;
      MODE_REPLACE: return STB_REPLACE;
      default:      return STB_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/cga_mic_stack_ctl_if.sv
// Sequencer-side commands and slice-side strobes/data of the return-address stack.
interface cga_mic_stack_ctl_if
  import cga_mic_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int DW = $clog2(DEPTH + 1);

  logic          CALL;
  logic          RET;
  logic          LDTOP;
  logic          CLR;
  logic [W-1:0]  PC;
  logic [W-1:0]  LDDATA;
  logic [W-1:0]  STOUT;
  logic [W-1:0]  STIN;
  logic          LOAD;
  logic          S3;
  logic          S3N;
  logic          S4NS3N;
  logic          S4S3N;
  logic [W-1:0]  RADDR;
  logic          RVALID;
  logic [DW-1:0] DEPTH_O;
  logic          EMPTY;
  logic          FULL;
  logic          OVF;
  logic          UNF;

  modport slave (
    input  CALL, RET, LDTOP, CLR, PC, LDDATA, STOUT,
    output STIN, LOAD, S3, S3N, S4NS3N, S4S3N,
           RADDR, RVALID, DEPTH_O, EMPTY, FULL, OVF, UNF
  );

  modport master (
    output CALL, RET, LDTOP, CLR, PC, LDDATA, STOUT,
    input  STIN, LOAD, S3, S3N, S4NS3N, S4S3N,
           RADDR, RVALID, DEPTH_O, EMPTY, FULL, OVF, UNF
  );

endinterface

// File: rtl/cga_mic_stack_mode_enc.sv
// Pure mode-to-strobe encoder; the only place slice strobe encodings are produced.
module cga_mic_stack_mode_enc
  import cga_mic_pkg::*;
(
  input  mode_e mode_i,
  output logic  load_o,
  output logic  s3_o,
  output logic  s3n_o,
  output logic  s4ns3n_o,
  output logic  s4s3n_o
);

  strobe_t stb;

  assign stb      = mode_strobes(mode_i);
  assign load_o   = stb.load;
  assign s3_o     = stb.s3;
  assign s3n_o    = ~stb.s3;
  assign s4ns3n_o = stb.s4ns3n;
  assign s4s3n_o  = stb.s4s3n;

endmodule

// File: rtl/cga_mic_stack_ctl.sv
// Return-address stack controller: decodes CALL/RET/LDTOP/CLR into slice modes,
// tracks depth and sticky overflow/underflow, and returns popped addresses.
module cga_mic_stack_ctl
  import cga_mic_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input logic                 CLK,
  input logic                 RSTN,
  cga_mic_stack_ctl_if.slave  bus
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  mode_e         mode_q, mode_d;
  logic [W-1:0]  stin_q, stin_d;
  logic [W-1:0]  raddr_q, raddr_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          empty, full;
  logic [W-1:0]  pc_inc;

  assign empty  = (depth_q == '0);
  assign full   = (depth_q == DEPTH_MAX);
  assign pc_inc = bus.PC + W'(1);

  // NOTE: every next-state signal gets a default first so no path leaves it
  // unassigned; otherwise this block would infer latches.
  always_comb begin
    mode_d   = MODE_HOLD;
    stin_d   = stin_q;
    raddr_d  = raddr_q;
    rvalid_d = 1'b0;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.CLR) begin
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (bus.CALL && bus.RET) begin
      // Return and call in one step: the top entry is swapped in place.
      stin_d   = pc_inc;
      raddr_d  = bus.STOUT;
      rvalid_d = 1'b1;
      if (empty) begin
        mode_d  = MODE_PUSH;
        depth_d = DW'(1);
      end else begin
        mode_d  = MODE_REPLACE;
      end
    end else if (bus.CALL) begin
      mode_d = MODE_PUSH;
      stin_d = pc_inc;
      if (full) ovf_d   = 1'b1;
      else      depth_d = depth_q + DW'(1);
    end else if (bus.RET) begin
      // The POP is issued even when empty so the slices stay in step.
      mode_d   = MODE_POP;
      raddr_d  = bus.STOUT;
      rvalid_d = 1'b1;
      if (empty) unf_d   = 1'b1;
      else       depth_d = depth_q - DW'(1);
    end else if (bus.LDTOP) begin
      stin_d = bus.LDDATA;
      if (empty) begin
        mode_d  = MODE_PUSH;
        depth_d = DW'(1);
      end else begin
        mode_d  = MODE_REPLACE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mode_q   <= MODE_HOLD;
      stin_q   <= '0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      stin_q   <= stin_d;
      raddr_q  <= raddr_d;
      rvalid_q <= rvalid_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  cga_mic_stack_mode_enc u_mode_enc (
    .mode_i   (mode_q),
    .load_o   (bus.LOAD),
    .s3_o     (bus.S3),
    .s3n_o    (bus.S3N),
    .s4ns3n_o (bus.S4NS3N),
    .s4s3n_o  (bus.S4S3N)
  );

  assign bus.STIN    = stin_q;
  assign bus.RADDR   = raddr_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.DEPTH_O = depth_q;
  assign bus.EMPTY   = empty;
  assign bus.FULL    = full;
  assign bus.OVF     = ovf_q;
  assign bus.UNF     = unf_q;

endmodule
